// File: rtl/microwave_pkg.sv
// microwave_pkg: shared types, defaults and keypad decode for the microwave controller
package microwave_pkg;
  typedef enum logic [2:0] {IDLE, ENTRY, PWR_ENTRY, COOK, PAUSED, DONE} mw_state_t;
  typedef logic [3:0] bcd_t;
  typedef struct packed {
    logic valid;
    bcd_t digit;
  } key_t;
  localparam int QUICK_S_DEFAULT = 30;
  function automatic key_t key_decode(input logic [9:0] k);
    key_t r;
    r.valid = (k != '0) && ((k & (k - 10'd1)) == '0);
    r.digit = '0;
    for (int i = 0; i < 10; i++) if (k[i]) r.digit = bcd_t'(i);
    return r;
  endfunction
endpackage

// File: rtl/mw_tick_gen.sv
// mw_tick_gen: one-second prescaler with clear and run-enable, one-cycle tick
module mw_tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic tick
);
  localparam int CW = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;
  logic [CW-1:0] cnt;
  assign tick = run && cnt == CW'(CLK_HZ - 1);
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (run) cnt <= tick ? '0 : cnt + CW'(1);
  end
endmodule

// File: rtl/microwave_ctrl_gen2.sv
// microwave_ctrl_gen2: keypad entry, BCD countdown, power duty cycling, pause/resume and beep
module microwave_ctrl_gen2
  import microwave_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int MIN_DIGITS = 1,
  parameter int PWR_LEVELS = 10,
  parameter int BEEP_S     = 3,
  parameter int QUICK_S    = QUICK_S_DEFAULT
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [9:0]                        keypad,
  input  logic                              pwr_key,
  input  logic                              start,
  input  logic                              stop,
  input  logic                              clear,
  input  logic                              door_closed,
  output logic                              mag,
  output logic                              beep,
  output logic                              busy,
  output logic [3:0]                        sec_ones,
  output logic [3:0]                        sec_tens,
  output logic [4*MIN_DIGITS-1:0]           mins,
  output logic [$clog2(PWR_LEVELS+1)-1:0]   power_level
);
  localparam int MW = 4 * MIN_DIGITS;
  localparam int PW = $clog2(PWR_LEVELS + 1);
  localparam int BW = BEEP_S > 1 ? $clog2(BEEP_S) : 1;
  mw_state_t state, state_n;
  bcd_t ones_n, tens_n, dec_ones, dec_tens;
  logic [MW-1:0] mins_n, dec_mins;
  logic [PW-1:0] power_n, phase, phase_n;
  logic [BW-1:0] beep_cnt, beep_cnt_n;
  logic tick, run, fresh, borrow, time_zero, dec_zero;
  key_t key;
  assign key = key_decode(keypad);
  assign time_zero = {mins, sec_tens, sec_ones} == '0;
  // Prescaler stops on the cycle COOK is left so a pause keeps the partial second intact
  assign run = (state == COOK && door_closed && !stop && !clear) || state == DONE;
  assign mag = state == COOK && door_closed && phase < power_level;
  assign beep = state == DONE;
  assign busy = state == COOK || state == PAUSED;
  mw_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (fresh),
    .run (run),
    .tick(tick)
  );
  always_comb begin
    dec_ones = sec_ones == '0 ? 4'd9 : sec_ones - 4'd1;
    dec_tens = sec_ones != '0 ? sec_tens : sec_tens == '0 ? 4'd5 : sec_tens - 4'd1;
    borrow = sec_ones == '0 && sec_tens == '0;
    dec_mins = mins;
    for (int i = 0; i < MIN_DIGITS; i++) begin
      dec_mins[4*i +: 4] = borrow ? (mins[4*i +: 4] == '0 ? 4'd9 : mins[4*i +: 4] - 4'd1) : mins[4*i +: 4];
      borrow = borrow && mins[4*i +: 4] == '0;
    end
    dec_zero = {dec_mins, dec_tens, dec_ones} == '0;
  end
  always_comb begin
    state_n = state;
    ones_n = sec_ones;
    tens_n = sec_tens;
    mins_n = mins;
    power_n = power_level;
    phase_n = phase;
    beep_cnt_n = beep_cnt;
    fresh = 1'b0;
    if (state == COOK && tick) begin
      {mins_n, tens_n, ones_n} = {dec_mins, dec_tens, dec_ones};
      phase_n = phase == PW'(PWR_LEVELS - 1) ? '0 : phase + PW'(1);
      beep_cnt_n = '0;
      state_n = dec_zero ? DONE : COOK;
    end
    if (state == DONE && tick) begin
      beep_cnt_n = beep_cnt + BW'(1);
      state_n = beep_cnt == BW'(BEEP_S - 1) ? IDLE : DONE;
    end
    if (clear) begin
      state_n = IDLE;
      {mins_n, tens_n, ones_n} = '0;
    end else if (!door_closed && (state == COOK || state == DONE)) begin
      state_n = state == COOK ? PAUSED : IDLE;
    end else if (stop) begin
      state_n = state == COOK ? PAUSED : (state == PAUSED || state == DONE) ? IDLE : state;
      if (state != COOK) {mins_n, tens_n, ones_n} = '0;
    end else if (start && door_closed && state != COOK && state != DONE) begin
      // A resume keeps prescaler and duty phase; a fresh start restarts both
      state_n = COOK;
      fresh = state != PAUSED;
      phase_n = state == PAUSED ? phase : '0;
      if (state != PAUSED && time_zero)
        {mins_n, tens_n, ones_n} = {MW'(0), bcd_t'(QUICK_S / 10), bcd_t'(QUICK_S % 10)};
    end else if (pwr_key && (state == IDLE || state == ENTRY)) begin
      state_n = PWR_ENTRY;
    end else if (key.valid) begin
      if (state == IDLE || state == ENTRY) begin
        mins_n = MW'({mins, sec_tens});
        tens_n = sec_ones;
        ones_n = key.digit;
        state_n = ENTRY;
      end else if (state == PWR_ENTRY) begin
        power_n = key.digit == '0 ? PW'(PWR_LEVELS) :
                  int'(key.digit) <= PWR_LEVELS ? PW'(key.digit) : power_level;
        state_n = ENTRY;
      end else if (state == DONE) begin
        state_n = IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sec_ones <= '0;
      sec_tens <= '0;
      mins <= '0;
      power_level <= PW'(PWR_LEVELS);
      phase <= '0;
      beep_cnt <= '0;
    end else begin
      state <= state_n;
      sec_ones <= ones_n;
      sec_tens <= tens_n;
      mins <= mins_n;
      power_level <= power_n;
      phase <= phase_n;
      beep_cnt <= beep_cnt_n;
    end
  end
endmodule

// File: tb/tb_microwave_ctrl_gen2.sv
// tb_microwave_ctrl_gen2: directed scenario checks for one- and two-minute-digit controllers
module tb_microwave_ctrl_gen2;
  logic clk = 1'b0, rst = 1'b1, pwr_key = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0, door_closed = 1'b1;
  logic [9:0] keypad = '0;
  logic mag, beep, busy, mag2, beep2, busy2;
  logic [3:0] sec_ones, sec_tens, mins, ones2, tens2, pwr, pwr2;
  logic [7:0] mins2;
  int total = 0, passed = 0;
  always #5 clk = ~clk;
  microwave_ctrl_gen2 #(.CLK_HZ(10), .MIN_DIGITS(1)) dut (
    .clk(clk), .rst(rst), .keypad(keypad), .pwr_key(pwr_key), .start(start), .stop(stop),
    .clear(clear), .door_closed(door_closed), .mag(mag), .beep(beep), .busy(busy),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .mins(mins), .power_level(pwr)
  );
  microwave_ctrl_gen2 #(.CLK_HZ(10), .MIN_DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .keypad(keypad), .pwr_key(pwr_key), .start(start), .stop(stop),
    .clear(clear), .door_closed(door_closed), .mag(mag2), .beep(beep2), .busy(busy2),
    .sec_ones(ones2), .sec_tens(tens2), .mins(mins2), .power_level(pwr2)
  );
  task automatic press(input logic s, input logic p, input logic c, input logic w, input logic [9:0] k);
    @(negedge clk);
    start = s; stop = p; clear = c; pwr_key = w; keypad = k;
    @(negedge clk);
    start = 1'b0; stop = 1'b0; clear = 1'b0; pwr_key = 1'b0; keypad = '0;
  endtask
  task automatic key(input int d);
    logic [9:0] k;
    k = 10'd1 << d;
    press(1'b0, 1'b0, 1'b0, 1'b0, k);
  endtask
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic test_reset;
    wait_cyc(3);
    rst = 1'b0;
    total++; if ({mins, sec_tens, sec_ones} !== 12'h000) $display("FAIL reset_time got %h want 000", {mins, sec_tens, sec_ones}); else passed++;
    total++; if (pwr !== 4'd10) $display("FAIL reset_power got %0d want 10", pwr); else passed++;
    total++; if ({mag, beep, busy} !== 3'b000) $display("FAIL reset_outputs got %b want 000", {mag, beep, busy}); else passed++;
    total++; if ({mins2, tens2, ones2} !== 16'h0000) $display("FAIL reset_time2 got %h want 0000", {mins2, tens2, ones2}); else passed++;
  endtask
  task automatic test_quick_start;
    press(1'b1, 1'b0, 1'b0, 1'b0, '0);
    total++; if ({mins, sec_tens, sec_ones} !== 12'h030) $display("FAIL quick_time got %h want 030", {mins, sec_tens, sec_ones}); else passed++;
    total++; if ({mag, beep, busy} !== 3'b101) $display("FAIL quick_outputs got %b want 101", {mag, beep, busy}); else passed++;
    wait_cyc(9);
    total++; if ({mins, sec_tens, sec_ones} !== 12'h030) $display("FAIL quick_before_tick got %h want 030", {mins, sec_tens, sec_ones}); else passed++;
    wait_cyc(1);
    total++; if ({mins, sec_tens, sec_ones} !== 12'h029) $display("FAIL quick_first_tick got %h want 029", {mins, sec_tens, sec_ones}); else passed++;
    press(1'b1, 1'b0, 1'b1, 1'b0, '0);
    total++; if ({mins, sec_tens, sec_ones, mag, busy} !== 14'h0000) $display("FAIL clear_start got %h want 0000", {mins, sec_tens, sec_ones, mag, busy}); else passed++;
  endtask
  task automatic test_countdown;
    key(1); key(3); key(0);
    total++; if ({mins, sec_tens, sec_ones} !== 12'h130) $display("FAIL entry_130 got %h want 130", {mins, sec_tens, sec_ones}); else passed++;
    press(1'b1, 1'b0, 1'b0, 1'b0, '0);
    wait_cyc(300);
    total++; if ({mins, sec_tens, sec_ones} !== 12'h100) $display("FAIL count_100 got %h want 100", {mins, sec_tens, sec_ones}); else passed++;
    wait_cyc(10);
    total++; if ({mins, sec_tens, sec_ones} !== 12'h059) $display("FAIL borrow_059 got %h want 059", {mins, sec_tens, sec_ones}); else passed++;
    wait_cyc(589);
    total++; if ({mins, sec_tens, sec_ones, beep, busy} !== 14'b00000000000101) $display("FAIL count_001 got %h want 005", {mins, sec_tens, sec_ones, beep, busy}); else passed++;
    wait_cyc(1);
    total++; if ({mins, sec_tens, sec_ones, beep, busy, mag} !== 15'b000000000000100) $display("FAIL done_entry got %h want 0004", {mins, sec_tens, sec_ones, beep, busy, mag}); else passed++;
    wait_cyc(29);
    total++; if (beep !== 1'b1) $display("FAIL beep_hold got %b want 1", beep); else passed++;
    wait_cyc(1);
    total++; if ({beep, busy} !== 2'b00) $display("FAIL beep_end got %b want 00", {beep, busy}); else passed++;
  endtask
  task automatic test_power;
    int cnt;
    press(1'b0, 1'b0, 1'b0, 1'b1, '0);
    key(3);
    total++; if (pwr !== 4'd3) $display("FAIL power_3 got %0d want 3", pwr); else passed++;
    key(1); key(0);
    total++; if ({mins, sec_tens, sec_ones} !== 12'h010) $display("FAIL power_time got %h want 010", {mins, sec_tens, sec_ones}); else passed++;
    press(1'b1, 1'b0, 1'b0, 1'b0, '0);
    total++; if (mag !== 1'b1) $display("FAIL duty_first got %b want 1", mag); else passed++;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (mag) cnt++;
      @(negedge clk);
    end
    total++; if (cnt !== 30) $display("FAIL duty_count got %0d want 30", cnt); else passed++;
    total++; if ({beep, mag, mins, sec_tens, sec_ones} !== 14'b10000000000000) $display("FAIL duty_done got %h want 2000", {beep, mag, mins, sec_tens, sec_ones}); else passed++;
    key(4);
    total++; if ({beep, mins, sec_tens, sec_ones} !== 13'h0000) $display("FAIL key_exit_done got %h want 0000", {beep, mins, sec_tens, sec_ones}); else passed++;
    press(1'b0, 1'b0, 1'b0, 1'b1, '0);
    press(1'b0, 1'b0, 1'b0, 1'b0, 10'b0000000011);
    key(5);
    total++; if ({pwr, mins, sec_tens, sec_ones} !== 16'h5000) $display("FAIL power_invalid_key got %h want 5000", {pwr, mins, sec_tens, sec_ones}); else passed++;
    press(1'b0, 1'b0, 1'b0, 1'b1, '0);
    key(0);
    total++; if (pwr !== 4'd10) $display("FAIL power_zero got %0d want 10", pwr); else passed++;
  endtask
  task automatic test_door_pause;
    key(1); key(0);
    press(1'b1, 1'b0, 1'b0, 1'b0, '0);
    wait_cyc(50);
    total++; if ({mins, sec_tens, sec_ones} !== 12'h005) $display("FAIL door_at_005 got %h want 005", {mins, sec_tens, sec_ones}); else passed++;
    wait_cyc(3);
    total++; if (mag !== 1'b1) $display("FAIL door_mag_before got %b want 1", mag); else passed++;
    door_closed = 1'b0;
    #1;
    total++; if (mag !== 1'b0) $display("FAIL door_mag_same_cycle got %b want 0", mag); else passed++;
    @(negedge clk);
    wait_cyc(30);
    total++; if ({busy, mag, mins, sec_tens, sec_ones} !== 14'b10000000000101) $display("FAIL paused_frozen got %h want 2005", {busy, mag, mins, sec_tens, sec_ones}); else passed++;
    door_closed = 1'b1;
    press(1'b1, 1'b0, 1'b0, 1'b0, '0);
    wait_cyc(6);
    total++; if ({mag, mins, sec_tens, sec_ones} !== 13'h1005) $display("FAIL resume_005 got %h want 1005", {mag, mins, sec_tens, sec_ones}); else passed++;
    wait_cyc(1);
    total++; if ({mins, sec_tens, sec_ones} !== 12'h004) $display("FAIL resume_partial got %h want 004", {mins, sec_tens, sec_ones}); else passed++;
  endtask
  task automatic test_stop;
    press(1'b0, 1'b1, 1'b0, 1'b0, '0);
    total++; if ({busy, mag, mins, sec_tens, sec_ones} !== 14'b10000000000100) $display("FAIL stop_pause got %h want 2004", {busy, mag, mins, sec_tens, sec_ones}); else passed++;
    press(1'b0, 1'b1, 1'b0, 1'b0, '0);
    total++; if ({busy, mins, sec_tens, sec_ones} !== 13'h0000) $display("FAIL stop_idle got %h want 0000", {busy, mins, sec_tens, sec_ones}); else passed++;
  endtask
  task automatic test_start_stop;
    key(4); key(2);
    total++; if ({mins, sec_tens, sec_ones} !== 12'h042) $display("FAIL entry_042 got %h want 042", {mins, sec_tens, sec_ones}); else passed++;
    press(1'b1, 1'b1, 1'b0, 1'b0, '0);
    total++; if ({busy, mins, sec_tens, sec_ones} !== 13'h0000) $display("FAIL start_stop got %h want 0000", {busy, mins, sec_tens, sec_ones}); else passed++;
    door_closed = 1'b0;
    press(1'b1, 1'b0, 1'b0, 1'b0, '0);
    total++; if ({busy, mins, sec_tens, sec_ones} !== 13'h0000) $display("FAIL start_door_open got %h want 0000", {busy, mins, sec_tens, sec_ones}); else passed++;
    door_closed = 1'b1;
  endtask
  task automatic test_raw_digits;
    key(9); key(9);
    press(1'b1, 1'b0, 1'b0, 1'b0, '0);
    wait_cyc(10);
    total++; if ({mins, sec_tens, sec_ones} !== 12'h098) $display("FAIL raw_098 got %h want 098", {mins, sec_tens, sec_ones}); else passed++;
    press(1'b0, 1'b0, 1'b1, 1'b0, '0);
    total++; if ({busy, mins, sec_tens, sec_ones} !== 13'h0000) $display("FAIL clear_cook got %h want 0000", {busy, mins, sec_tens, sec_ones}); else passed++;
  endtask
  task automatic test_min_digits2;
    key(1); key(2); key(0); key(0);
    total++; if ({mins2, tens2, ones2} !== 16'h1200) $display("FAIL min2_1200 got %h want 1200", {mins2, tens2, ones2}); else passed++;
    key(7);
    total++; if ({mins2, tens2, ones2} !== 16'h2007) $display("FAIL min2_drop got %h want 2007", {mins2, tens2, ones2}); else passed++;
    total++; if ({mins, sec_tens, sec_ones} !== 12'h007) $display("FAIL min1_drop got %h want 007", {mins, sec_tens, sec_ones}); else passed++;
    press(1'b0, 1'b0, 1'b1, 1'b0, '0);
    key(1); key(2); key(0); key(0);
    press(1'b1, 1'b0, 1'b0, 1'b0, '0);
    wait_cyc(10);
    total++; if ({mins2, tens2, ones2} !== 16'h1159) $display("FAIL min2_borrow got %h want 1159", {mins2, tens2, ones2}); else passed++;
    press(1'b0, 1'b0, 1'b1, 1'b0, '0);
  endtask
  initial begin
    test_reset;
    test_quick_start;
    test_countdown;
    test_power;
    test_door_pause;
    test_stop;
    test_start_stop;
    test_raw_digits;
    test_min_digits2;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
